code_lock: RTL and testbench

- Parametrised successor to the single-key electric lock: unlocks only after a multi-digit code is entered on a one-hot 10-key pad.
- Adds press edge detection, digit buffering, a failed-attempt counter and a timed lockout.
- Sits between the tenkey pad (debounced upstream) and the bolt actuator; `close` comes from the door sensor.

---
 rtl/code_lock.sv | 147 ++++++++++++++
 tb/tb_code_lock.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock.sv
// Multi-digit keypad lock: edge-detected one-hot key presses, code check, fail counter and timed lockout.
// Optional timed auto re-lock while open is enabled by defining CODE_LOCK_AUTOLOCK_EN.
module code_lock #(
  parameter int unsigned DIGITS          = 4,
  parameter logic [4*DIGITS-1:0] PASSCODE = 16'h5963,
  parameter int unsigned MAX_FAIL        = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 16,
  parameter int unsigned AUTOLOCK_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tenkey,
  input  logic       close,
  output logic       lock,
  output logic       fail,
  output logic       lockout,
  output logic [3:0] digit_cnt
);

  localparam int unsigned BUF_W  = 4 * DIGITS;
  localparam int unsigned FCNT_W = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

  if (DIGITS < 1 || DIGITS > 8 || MAX_FAIL < 1 || MAX_FAIL > 15 ||
      LOCKOUT_CYCLES < 1 || AUTOLOCK_CYCLES < 1) begin : g_param_err
    $error("code_lock: parameter out of range");
  end

  typedef enum logic [1:0] {S_LOCKED, S_CHECK, S_OPEN, S_LOCKOUT} state_t;

  state_t            state, state_d;
  logic [9:0]        tenkey_q;
  logic [BUF_W-1:0]  code_buf, code_buf_d;
  logic [FCNT_W-1:0] fail_cnt, fail_cnt_d, fail_cnt_inc_c;
  logic [TMR_W-1:0]  timer, timer_d;
  logic [3:0]        digit_cnt_d, digit_c;
  logic              lock_d, fail_d, lockout_d;
  logic              onehot_c, press_c, match_c, autolock_c;

  // Key decode: a press is a fresh one-hot pattern after a fully released pad
  always_comb begin
    digit_c = '0;
    for (int i = 0; i < 10; i++) begin
      if (tenkey[i]) digit_c = 4'(i);
    end
    onehot_c = (tenkey != '0) && ((tenkey & (tenkey - 10'd1)) == '0);
    press_c  = onehot_c && (tenkey_q == '0);
  end

  assign match_c        = (code_buf == PASSCODE);
  assign fail_cnt_inc_c = fail_cnt + FCNT_W'(1);

`ifdef CODE_LOCK_AUTOLOCK_EN
  localparam int unsigned AUTO_W = $clog2(AUTOLOCK_CYCLES + 1);
  logic [AUTO_W-1:0] open_cnt, open_cnt_d;

  assign autolock_c = (state == S_OPEN) && (open_cnt == AUTO_W'(1));

  always_comb begin
    open_cnt_d = open_cnt;
    if (state == S_CHECK && match_c) open_cnt_d = AUTO_W'(AUTOLOCK_CYCLES);
    else if (state == S_OPEN)        open_cnt_d = open_cnt - AUTO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) open_cnt <= '0;
    else        open_cnt <= open_cnt_d;
  end
`else
  assign autolock_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOCKED;
      tenkey_q  <= '0;
      code_buf  <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
      lock      <= 1'b1;
      fail      <= 1'b0;
      lockout   <= 1'b0;
      digit_cnt <= '0;
    end else begin
      state     <= state_d;
      tenkey_q  <= tenkey;
      code_buf  <= code_buf_d;
      fail_cnt  <= fail_cnt_d;
      timer     <= timer_d;
      lock      <= lock_d;
      fail      <= fail_d;
      lockout   <= lockout_d;
      digit_cnt <= digit_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_LOCKED:  if (!close && press_c && digit_cnt == 4'(DIGITS - 1)) state_d = S_CHECK;
      S_CHECK: begin
        if (match_c)                                 state_d = S_OPEN;
        else if (fail_cnt_inc_c == FCNT_W'(MAX_FAIL)) state_d = S_LOCKOUT;
        else                                         state_d = S_LOCKED;
      end
      S_OPEN:    if (close || autolock_c) state_d = S_LOCKED;
      S_LOCKOUT: if (timer == TMR_W'(1))  state_d = S_LOCKED;
      default:   state_d = S_LOCKED;
    endcase
  end

  // Output and datapath next values; outputs follow the state being entered
  always_comb begin
    lock_d      = (state_d != S_OPEN);
    lockout_d   = (state_d == S_LOCKOUT);
    fail_d      = (state == S_CHECK) && !match_c;
    digit_cnt_d = '0;
    code_buf_d  = code_buf;
    fail_cnt_d  = fail_cnt;
    timer_d     = timer;
    unique case (state)
      S_LOCKED: begin
        if (close) begin
          code_buf_d = '0;
        end else if (press_c) begin
          code_buf_d  = (code_buf << 4) | BUF_W'(digit_c);
          digit_cnt_d = digit_cnt + 4'd1;
        end else begin
          digit_cnt_d = digit_cnt;
        end
      end
      S_CHECK: begin
        code_buf_d = '0;
        fail_cnt_d = match_c ? '0 : fail_cnt_inc_c;
        if (state_d == S_LOCKOUT) timer_d = TMR_W'(LOCKOUT_CYCLES);
      end
      S_LOCKOUT: begin
        timer_d = timer - TMR_W'(1);
        if (state_d == S_LOCKED) fail_cnt_d = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_code_lock.sv
// Self-checking bench for code_lock: directed scenarios plus random key traffic against an entry-level model.
module tb_code_lock;

  localparam int DIGITS   = 4;
  localparam int PASSCODE = 'h5963;
  localparam int MAX_FAIL = 3;
  localparam int LOCKOUT  = 16;
  localparam int AUTOLOCK = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] tenkey;
  logic       close;
  logic       lock, fail, lockout;
  logic [3:0] digit_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int lo_count = 0;

  code_lock #(
    .DIGITS(DIGITS), .PASSCODE(16'h5963), .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYCLES(LOCKOUT), .AUTOLOCK_CYCLES(AUTOLOCK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tenkey(tenkey), .close(close),
    .lock(lock), .fail(fail), .lockout(lockout), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && lockout) lo_count++;

  // Reference model: digits entered so far, pending evaluation, open flag, fail count, lockout time left
  int         m_q[$];
  bit         m_pend, m_open, m_fail;
  int         m_age, m_fails, m_timer;
  logic [9:0] m_prev;

  function automatic void model_reset();
    m_q.delete();
    m_pend = 0; m_open = 0; m_fail = 0;
    m_age = 0; m_fails = 0; m_timer = 0;
    m_prev = '0;
  endfunction

  function automatic void model_step(logic [9:0] tk, bit cl);
    int  d, code;
    bit  pressed;
    d = 0;
    for (int i = 0; i < 10; i++) if (tk[i]) d = i;
    pressed = ($countones(tk) == 1) && (m_prev == '0);
    m_prev = tk;
    m_fail = 0;
    if (m_timer > 0) begin
      m_timer--;
      if (m_timer == 0) m_fails = 0;
    end else if (m_pend) begin
      code = 0;
      foreach (m_q[i]) code = code * 16 + m_q[i];
      m_q.delete();
      m_pend = 0;
      if (code == PASSCODE) begin
        m_open = 1; m_age = 0; m_fails = 0;
      end else begin
        m_fails++;
        m_fail = 1;
        if (m_fails == MAX_FAIL) m_timer = LOCKOUT;
      end
    end else if (m_open) begin
      m_age++;
      if (cl) m_open = 0;
`ifdef CODE_LOCK_AUTOLOCK_EN
      else if (m_age == AUTOLOCK) m_open = 0;
`endif
    end else if (cl) begin
      m_q.delete();
    end else if (pressed) begin
      m_q.push_back(d);
      if (m_q.size() == DIGITS) m_pend = 1;
    end
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("lock", int'(lock), int'(!m_open));
    check("fail", int'(fail), int'(m_fail));
    check("lockout", int'(lockout), int'(m_timer > 0));
    check("digit_cnt", int'(digit_cnt), int'(m_q.size()));
  endtask

  task automatic cycle(input logic [9:0] tk, input bit cl);
    tenkey = tk;
    close  = cl;
    @(posedge clk);
    model_step(tk, cl);
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [9:0] key(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  task automatic press(input int d);
    cycle(key(d), 0);
    cycle(key(d), 0);
    cycle('0, 0);
  endtask

  task automatic enter(input int code);
    for (int i = DIGITS - 1; i >= 0; i--) press((code >> (4 * i)) & 15);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
    $fatal(1);
  end

  initial begin
    int lo_start, low_cycles;
    rst_n = 1'b0; tenkey = '0; close = 1'b0;
    model_reset();
    #12;
    check("rst_lock", int'(lock), 1);
    check("rst_fail", int'(fail), 0);
    check("rst_lockout", int'(lockout), 0);
    check("rst_digit_cnt", int'(digit_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle('0, 0);

    // Correct code opens, close relocks
    enter(PASSCODE);
    check("unlock", int'(lock), 0);
    cycle('0, 1);
    check("relock", int'(lock), 1);

    // Three wrong codes lock out; entries during lockout are ignored
    enter('h1234);
    enter('h1234);
    lo_start = lo_count;
    enter('h1234);
    enter(PASSCODE);
    check("lockout_ignores", int'(lock), 1);
    for (int i = 0; i < 10; i++) cycle('0, 0);
    check("lockout_len", lo_count - lo_start, LOCKOUT);
    enter(PASSCODE);
    check("unlock_after_lockout", int'(lock), 0);
    cycle('0, 1);

    // Held key counts once; multi-hot is not a press
    for (int i = 0; i < 10; i++) cycle(key(5), 0);
    cycle('0, 0);
    check("hold_once", int'(digit_cnt), 1);
    cycle(10'b0000100001, 0);
    cycle(10'b0000100001, 0);
    cycle('0, 0);
    check("multihot", int'(digit_cnt), 1);
    cycle('0, 1);

    // Close clears a partial entry and drops a coincident press
    press(5);
    press(9);
    cycle(key(6), 1);
    check("close_clear", int'(digit_cnt), 0);
    cycle('0, 0);
    enter(PASSCODE);
    check("unlock_after_clear", int'(lock), 0);
    cycle('0, 1);

    // Correct code clears the fail count
    enter('h1111);
    enter('h2222);
    enter(PASSCODE);
    cycle('0, 1);
    enter('h3333);
    check("no_lockout", int'(lockout), 0);

    // Open duration without close
    enter(PASSCODE);
    low_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      cycle('0, 0);
      if (!lock) low_cycles++;
    end
`ifdef CODE_LOCK_AUTOLOCK_EN
    check("autolock_len", low_cycles + 1, AUTOLOCK);
`else
    check("stays_open", low_cycles, 40);
`endif
    cycle('0, 1);

    // Random key traffic
    for (int n = 0; n < 600; n++) begin
      int sel, hold;
      sel  = int'($urandom_range(0, 99));
      hold = int'($urandom_range(1, 3));
      if (sel < 20) begin
        enter(PASSCODE);
      end else if (sel < 65) begin
        int d;
        d = int'($urandom_range(0, 9));
        for (int h = 0; h < hold; h++) cycle(key(d), 0);
        cycle('0, 0);
      end else if (sel < 78) begin
        cycle('0, 1);
      end else if (sel < 88) begin
        cycle('0, 0);
      end else begin
        logic [9:0] pat;
        pat = 10'($urandom);
        for (int h = 0; h < hold; h++) cycle(pat, $urandom_range(0, 4) == 0);
        cycle('0, 0);
      end
    end

    // Drive into lockout, then reset asynchronously between edges
    for (int i = 0; i < 40 && (m_timer > 0 || m_pend); i++) cycle('0, 0);
    if (m_open) cycle('0, 1);
    for (int i = 0; i < MAX_FAIL && m_timer == 0; i++) enter('h0000);
    for (int i = 0; i < 3; i++) cycle('0, 0);
    check("pre_reset_lockout", int'(lockout), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_lockout", int'(lockout), 0);
    check("async_lock", int'(lock), 1);
    check("async_digit_cnt", int'(digit_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle('0, 0);
    enter(PASSCODE);
    check("unlock_after_reset", int'(lock), 0);
    cycle('0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
